// File: rtl/cpu_bp_pkg.sv
// ============================================================================
// Module      : cpu_bp_pkg
// Description : Shared encodings for the branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam int BP_STATIC  = 0;
  localparam int BP_BIMODAL = 1;

endpackage

`default_nettype wire

// File: rtl/sat_counter2.sv
// ============================================================================
// Module      : sat_counter2
// Description : Next-state logic of a 2-bit saturating taken/not-taken counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter2
  import cpu_bp_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_taken,
  output logic [1:0] o_ctr
);

  always_comb begin
    o_ctr = i_ctr;
    if (i_taken) begin
      if (i_ctr != ST) o_ctr = i_ctr + 2'd1;
    end else begin
      if (i_ctr != SNT) o_ctr = i_ctr - 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
// Module      : branch_predictor
// Description : Static or bimodal branch predictor with a flop-based target
//               buffer, mispredict detection and a saturating mispredict count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor
  import cpu_bp_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int MODE    = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_pred_taken_i,
  input  logic [ADDR_W-1:0] upd_pred_target_i,
  output logic              flush_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic [31:0]       mispred_cnt_o
);

  localparam int c_IDX_W = $clog2(ENTRIES);
  localparam int c_TAG_W = ADDR_W - c_IDX_W - 2;

  logic              w_pred_taken;
  logic [ADDR_W-1:0] w_pred_target;
  logic              w_flush;
  logic [ADDR_W-1:0] w_redirect;
  logic [31:0]       r_mispred_cnt;

  // A taken branch that went to the wrong target is a mispredict too.
  assign w_flush = upd_valid_i &&
                   ((upd_taken_i != upd_pred_taken_i) ||
                    (upd_taken_i && (upd_pred_target_i != upd_target_i)));

  assign w_redirect = !w_flush     ? '0 :
                      upd_taken_i ? upd_target_i : upd_pc_i + ADDR_W'(4);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mispred_cnt <= '0;
    end else if (w_flush && (r_mispred_cnt != 32'hFFFF_FFFF)) begin
      r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  generate
    if (MODE == BP_BIMODAL) begin : g_bimodal
      logic               r_valid  [ENTRIES];
      logic [c_TAG_W-1:0] r_tag    [ENTRIES];
      logic [ADDR_W-1:0]  r_target [ENTRIES];
      logic [1:0]         r_ctr    [ENTRIES];

      logic [c_IDX_W-1:0] w_lk_idx;
      logic [c_TAG_W-1:0] w_lk_tag;
      logic               w_lk_hit;
      logic [c_IDX_W-1:0] w_up_idx;
      logic [c_TAG_W-1:0] w_up_tag;
      logic               w_up_hit;
      logic [1:0]         w_ctr_next;
      logic [1:0]         w_unused_pc;

      assign w_lk_idx    = pc_i[c_IDX_W+1:2];
      assign w_lk_tag    = pc_i[ADDR_W-1:c_IDX_W+2];
      assign w_up_idx    = upd_pc_i[c_IDX_W+1:2];
      assign w_up_tag    = upd_pc_i[ADDR_W-1:c_IDX_W+2];
      assign w_unused_pc = pc_i[1:0];

      // Lookup reads the registered table directly, so a same-cycle update
      // only becomes visible after the edge.
      assign w_lk_hit      = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
      assign w_pred_taken  = !rst_i && w_lk_hit && r_ctr[w_lk_idx][1];
      assign w_pred_target = w_pred_taken ? r_target[w_lk_idx] : '0;

      assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

      sat_counter2 u_sat_counter2 (
        .i_ctr   (r_ctr[w_up_idx]),
        .i_taken (upd_taken_i),
        .o_ctr   (w_ctr_next)
      );

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= WNT;
          end
        end else if (upd_valid_i) begin
          if (w_up_hit) begin
            r_ctr[w_up_idx] <= w_ctr_next;
            if (upd_taken_i) r_target[w_up_idx] <= upd_target_i;
          end else if (upd_taken_i) begin
            r_valid[w_up_idx]  <= 1'b1;
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= upd_target_i;
            r_ctr[w_up_idx]    <= WT;
          end
        end
      end
    end else begin : g_static
      logic w_unused_lookup;

      assign w_unused_lookup = ^pc_i;
      assign w_pred_taken    = 1'b0;
      assign w_pred_target   = '0;
    end
  endgenerate

  assign pred_taken_o  = w_pred_taken;
  assign pred_target_o = w_pred_target;
  assign flush_o       = w_flush;
  assign redirect_pc_o = w_redirect;
  assign mispred_cnt_o = r_mispred_cnt;

endmodule

`default_nettype wire

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ADDR_W, default 32, sets the PC and target width in bits.
REQ-002 Parameter ENTRIES, default 16, sets the table depth; legal values are powers of 2 from 2 to 256.
REQ-003 Parameter MODE, default 1, selects the predictor: 0 = static not-taken, 1 = 2-bit bimodal with target buffer.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  asynchronous reset, active-high.
REQ-006 pc_i  input  ADDR_W  fetch PC (IF stage) for lookup.
REQ-007 pred_taken_o  output  1  prediction that fetch redirects to pred_target_o.
REQ-008 pred_target_o  output  ADDR_W  predicted target; 0 when pred_taken_o=0.
REQ-009 upd_valid_i  input  1  a branch was resolved in ID this cycle.
REQ-010 upd_pc_i  input  ADDR_W  PC of the resolved branch.
REQ-011 upd_taken_i  input  1  actual outcome.
REQ-012 upd_target_i  input  ADDR_W  actual taken target.
REQ-013 upd_pred_taken_i / upd_pred_target_i  input  1 / ADDR_W  prediction carried down with the branch through IF/ID.
REQ-014 flush_o  output  1  mispredict; IF/ID SHALL be flushed.
REQ-015 redirect_pc_o  output  ADDR_W  corrected fetch PC when flush_o=1.
REQ-016 mispred_cnt_o  output  32  saturating mispredict count.

Function
REQ-017 Index = PC[IDX_W+1:2] and tag = PC[ADDR_W-1:IDX_W+2], where IDX_W = log2(ENTRIES).
REQ-018 Each entry SHALL hold valid, tag, target, and a 2-bit counter: SNT=00, WNT=01, WT=10, ST=11.
REQ-019 Lookup SHALL be combinational and zero-latency: pred_taken_o = MODE==1 && valid && tag match && counter[1].
REQ-020 On upd_valid_i with a hit at the next edge: the counter saturates up when taken and down when not taken (ST+taken stays ST, SNT+not-taken stays SNT); target is rewritten only when taken.
REQ-021 On upd_valid_i with a miss and taken: the entry is allocated/overwritten with valid=1, the new tag, upd_target_i, and counter WT.
REQ-022 On upd_valid_i with a miss and not-taken: no table write.
REQ-023 When lookup and update target the same index in the same cycle, the lookup SHALL see pre-update contents (no bypass).
REQ-024 flush_o = upd_valid_i && (upd_taken_i != upd_pred_taken_i || (upd_taken_i && upd_pred_target_i != upd_target_i)); it is combinational.
REQ-025 redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i+4 (modulo 2^ADDR_W); it is 0 when flush_o=0.
REQ-026 mispred_cnt_o SHALL increment by 1 on each edge where flush_o=1 and saturate at 0xFFFFFFFF.
REQ-027 In MODE 0 there SHALL be no table writes, and pred_taken_o SHALL be 0; flush_o follows REQ-024.

Reset
REQ-028 rst_i SHALL immediately clear all valid bits, set all counters to WNT, and clear mispred_cnt_o, regardless of the clock.
REQ-029 During reset: pred_taken_o=0, pred_target_o=0, and table/counter writes are blocked even if upd_valid_i=1.
REQ-030 Reset asserted mid-update SHALL discard that update; the first update after release behaves as a miss.

Structure
REQ-031 Shared package cpu_bp_pkg SHALL hold the counter encodings (SNT/WNT/WT/ST) and the MODE constants (BP_STATIC=0, BP_BIMODAL=1).
REQ-032 The saturating 2-bit counter next-state logic SHALL be a sub-module sat_counter2, instantiated once on the update path.
REQ-033 The table SHALL be flip-flop based (no RAM macro) so that the read is asynchronous.

Verification
REQ-034 Reset, then pc_i=0x100 -> pred_taken_o=0, pred_target_o=0, mispred_cnt_o=0.
REQ-035 Update pc=0x100, taken, target=0x200, pred_taken=0 -> flush_o=1, redirect_pc_o=0x200; next cycle pc_i=0x100 gives pred_taken_o=1, target 0x200; count=1.
REQ-036 Two not-taken updates at 0x100 from WT -> WT->WNT->SNT, pred_taken_o=0; a third not-taken stays SNT; the not-taken mispredict sets redirect_pc_o=0x104.
REQ-037 ENTRIES=16, allocate 0x100 then a taken update at alias 0x140 (same index, different tag) -> 0x100 misses and 0x140 hits with the new target.
REQ-038 Same-cycle lookup and update on 0x100 -> the output reflects the old entry, and the new value appears next cycle; rst_i pulsed mid-sequence -> all lookups miss and count=0.
REQ-039 MODE=0, taken update at 0x100 -> flush_o=1, and a later lookup still gives pred_taken_o=0.
